// File: rtl/cpu_pkg.sv
// Shared definitions for the cpu_mc multicycle core.
// Opcodes, FSM states, instruction field positions and writeback decode.
package cpu_pkg;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_SHR  = 4'h2;
  localparam logic [3:0] OP_SHL  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_AND  = 4'h5;
  localparam logic [3:0] OP_NOT  = 4'h6;
  localparam logic [3:0] OP_XOR  = 4'h7;
  localparam logic [3:0] OP_JMP  = 4'h8;
  localparam logic [3:0] OP_BR   = 4'h9;
  localparam logic [3:0] OP_ST   = 4'hA;
  localparam logic [3:0] OP_LD   = 4'hB;
  localparam logic [3:0] OP_LI   = 4'hC;
  localparam logic [3:0] OP_CEQ  = 4'hD;
  localparam logic [3:0] OP_CLT  = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_t;

  localparam int OP_HI  = 15;
  localparam int OP_LO  = 12;
  localparam int RD_HI  = 11;
  localparam int RD_LO  = 8;
  localparam int RA_HI  = 7;
  localparam int RA_LO  = 4;
  localparam int RB_HI  = 3;
  localparam int RB_LO  = 0;
  localparam int IMM_HI = 7;
  localparam int IMM_LO = 0;

  function automatic logic op_writes(input logic [3:0] op);
    return !(op inside {OP_BR, OP_ST, OP_CEQ, OP_CLT, OP_HALT});
  endfunction

endpackage

// File: rtl/cpu_alu.sv
// Combinational ALU for the eight register-register ops; results wrap mod 2^W.
// Zero latency, no handshake.
module cpu_alu
  import cpu_pkg::*;
#(
  parameter int W = 16
) (
  input  logic [3:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y
);

  localparam logic [W-1:0] W_LIM = W'(W);

  always_comb begin
    y = '0;
    case (op)
      OP_ADD: y = a + b;
      OP_SUB: y = a - b;
      OP_SHR: y = (b >= W_LIM) ? '0 : (a >> b);
      OP_SHL: y = (b >= W_LIM) ? '0 : (a << b);
      OP_OR:  y = a | b;
      OP_AND: y = a & b;
      OP_NOT: y = ~a;
      OP_XOR: y = a ^ b;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/cpu_mc.sv
// Multicycle core: FETCH/DECODE/EXEC/[MEM]/WB, 4 cycles per op, 4+N for load/store.
// Data accesses hold DREQ/DA/RW until DACK, so slow memories stall the core.
module cpu_mc
  import cpu_pkg::*;
#(
  parameter int             W        = 16,
  parameter logic [W-1:0]   RESET_PC = '0
) (
  input  logic         CK,
  input  logic         RST,
  output logic [W-1:0] IA,
  input  logic [15:0]  ID,
  output logic [W-1:0] DA,
  inout  wire  [W-1:0] DD,
  output logic         RW,
  output logic         DREQ,
  input  logic         DACK,
  output logic         HALTED
);

  state_t       state, state_nxt;
  logic [15:0]  instr;
  logic [W-1:0] pc, a_q, b_q, res_q, npc_q, st_dat;
  logic         flag, cmp_q;
  logic [W-1:0] rf [16];

  logic [3:0]   op, rd, ra, rb;
  logic [7:0]   imm;
  logic [W-1:0] alu_y, pc_inc, ex_res, ex_npc;
  logic         ex_cmp, is_mem;
  logic         do_fetch, do_dec, do_exec, mem_done, do_wb;

  assign op     = instr[OP_HI:OP_LO];
  assign rd     = instr[RD_HI:RD_LO];
  assign ra     = instr[RA_HI:RA_LO];
  assign rb     = instr[RB_HI:RB_LO];
  assign imm    = instr[IMM_HI:IMM_LO];
  assign is_mem = (op == OP_LD) || (op == OP_ST);
  assign pc_inc = pc + W'(1);

  assign IA = pc;
  assign DD = RW ? {W{1'bz}} : st_dat;

  cpu_alu #(.W(W)) u_alu (
    .op (op),
    .a  (a_q),
    .b  (b_q),
    .y  (alu_y)
  );

  // Non-ALU results and next PC; BR samples FLAG here, before any later compare retires.
  always_comb begin
    ex_res = alu_y;
    ex_npc = pc_inc;
    ex_cmp = 1'b0;
    case (op)
      OP_JMP: begin
        ex_res = pc_inc;
        ex_npc = b_q;
      end
      OP_BR:  ex_npc = flag ? b_q : pc_inc;
      OP_LI:  ex_res = W'(imm);
      OP_CEQ: ex_cmp = (a_q == b_q);
      OP_CLT: ex_cmp = (a_q < b_q);
      default: ;
    endcase
  end

  always_ff @(posedge CK or negedge RST) begin
    if (!RST) state <= S_FETCH;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_FETCH:  state_nxt = S_DECODE;
      S_DECODE: state_nxt = S_EXEC;
      S_EXEC:   state_nxt = is_mem ? S_MEM : S_WB;
      S_MEM:    if (DREQ && DACK) state_nxt = S_WB;
      S_WB:     state_nxt = (op == OP_HALT) ? S_HALT : S_FETCH;
      S_HALT:   state_nxt = S_HALT;
      default:  state_nxt = S_FETCH;
    endcase
  end

  always_comb begin
    do_fetch = 1'b0;
    do_dec   = 1'b0;
    do_exec  = 1'b0;
    mem_done = 1'b0;
    do_wb    = 1'b0;
    case (state)
      S_FETCH:  do_fetch = 1'b1;
      S_DECODE: do_dec   = 1'b1;
      S_EXEC:   do_exec  = 1'b1;
      S_MEM:    mem_done = DREQ && DACK;
      S_WB:     do_wb    = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge CK or negedge RST) begin
    if (!RST) begin
      pc     <= RESET_PC;
      instr  <= '0;
      a_q    <= '0;
      b_q    <= '0;
      res_q  <= '0;
      npc_q  <= '0;
      cmp_q  <= 1'b0;
      flag   <= 1'b0;
      st_dat <= '0;
      DA     <= '0;
      DREQ   <= 1'b0;
      RW     <= 1'b1;
      HALTED <= 1'b0;
    end else begin
      if (do_fetch) instr <= ID;
      if (do_dec) begin
        a_q <= rf[ra];
        b_q <= rf[rb];
      end
      if (do_exec) begin
        res_q <= ex_res;
        npc_q <= ex_npc;
        cmp_q <= ex_cmp;
        if (is_mem) begin
          DA     <= (op == OP_ST) ? b_q : a_q;
          st_dat <= a_q;
          DREQ   <= 1'b1;
          RW     <= (op != OP_ST);
        end
      end
      if (mem_done) begin
        if (op == OP_LD) res_q <= DD;
        DREQ <= 1'b0;
        RW   <= 1'b1;
      end
      if (do_wb) begin
        if (op == OP_HALT) HALTED <= 1'b1;
        else               pc     <= npc_q;
        if ((op == OP_CEQ) || (op == OP_CLT)) flag <= cmp_q;
      end
    end
  end

  always_ff @(posedge CK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < 16; i++) rf[i] <= '0;
    end else if (do_wb && op_writes(op)) begin
      rf[rd] <= res_q;
    end
  end

endmodule

// File: tb/tb_cpu_mc.sv
// Directed bench for cpu_mc: a W=16 core for timing, memory and branch cases,
// and a W=32 core for wide shifts, wraparound subtract and JMP.
module tb_cpu_mc;

  logic ck = 1'b0;
  always #5 ck = ~ck;

  logic        rst16, dack16, rw16, dreq16, halted16;
  logic [15:0] ia16, id16, da16;
  wire  [15:0] dd16;
  logic        dd_en;
  logic [15:0] dd_val;
  logic [15:0] rom16 [64];

  logic        rst32, dack32, rw32, dreq32, halted32;
  logic [31:0] ia32, da32;
  logic [15:0] id32;
  wire  [31:0] dd32;
  logic [15:0] rom32 [64];

  assign id16 = rom16[ia16[5:0]];
  assign id32 = rom32[ia32[5:0]];
  assign dd16 = dd_en ? dd_val : 16'hzzzz;

  cpu_mc #(.W(16), .RESET_PC(16'h0000)) u16 (
    .CK(ck), .RST(rst16), .IA(ia16), .ID(id16), .DA(da16), .DD(dd16),
    .RW(rw16), .DREQ(dreq16), .DACK(dack16), .HALTED(halted16)
  );

  cpu_mc #(.W(32), .RESET_PC(32'h0)) u32 (
    .CK(ck), .RST(rst32), .IA(ia32), .ID(id32), .DA(da32), .DD(dd32),
    .RW(rw32), .DREQ(dreq32), .DACK(dack32), .HALTED(halted32)
  );

  int tests = 0;
  int fails = 0;
  int dreq_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge ck);
    #1;
  endtask

  task automatic restart16();
    @(negedge ck) rst16 = 1'b0;
    tick(1);
    @(negedge ck) rst16 = 1'b1;
  endtask

  initial begin
    rst16 = 1'b1; rst32 = 1'b1;
    dack16 = 1'b0; dack32 = 1'b0;
    dd_en = 1'b0; dd_val = 16'h0;
    for (int i = 0; i < 64; i++) begin
      rom16[i] = 16'hF000;
      rom32[i] = 16'hF000;
    end
    rom16[0] = 16'hC105;   // LI  R1,05
    rom16[1] = 16'hC203;   // LI  R2,03
    rom16[2] = 16'h0312;   // ADD R3,R1,R2
    rom16[3] = 16'hF000;   // HALT
    #2 rst16 = 1'b0; rst32 = 1'b0;
    tick(2);

    chk("rst_ia", ia16, 32'h0);
    chk("rst_dreq", dreq16, 32'h0);
    chk("rst_rw", rw16, 32'h1);
    chk("rst_da", da16, 32'h0);
    chk("rst_halted", halted16, 32'h0);

    // Straight-line ALU program, HALTED on cycle 16.
    @(negedge ck) rst16 = 1'b1;
    tick(15);
    chk("halt_c15", halted16, 32'h0);
    tick(1);
    chk("halt_c16", halted16, 32'h1);
    chk("add_r3", u16.rf[3], 32'h0008);
    tick(3);
    chk("halt_ia", ia16, 32'h3);

    // Memory, compare and branch program.
    rom16[2]  = 16'hA012;  // ST  R1->[R2]
    rom16[3]  = 16'hB420;  // LD  R4,[R2]
    rom16[4]  = 16'hC510;  // LI  R5,10
    rom16[5]  = 16'hD011;  // CEQ R1,R1
    rom16[6]  = 16'h9005;  // BR  R5
    rom16[16] = 16'hE012;  // CLT R1,R2
    rom16[17] = 16'h9005;  // BR  R5 (not taken)
    rom16[18] = 16'hF000;  // HALT
    restart16();

    tick(8);
    chk("st_pre_ia", ia16, 32'h2);
    tick(3);
    dreq_cnt = int'(dreq16);
    chk("st_rw", rw16, 32'h0);
    chk("st_da", da16, 32'h3);
    chk("st_dd", dd16, 32'h5);
    for (int c = 0; c < 2; c++) begin
      tick(1);
      dreq_cnt += int'(dreq16);
      chk("st_dd_hold", dd16, 32'h5);
      chk("st_rw_hold", rw16, 32'h0);
    end
    dack16 = 1'b1;
    tick(1);
    dack16 = 1'b0;
    dreq_cnt += int'(dreq16);
    chk("st_dreq_cycles", dreq_cnt, 32'd3);
    chk("st_rw_done", rw16, 32'h1);
    chk("st_ia_c14", ia16, 32'h2);
    tick(1);
    chk("st_ia_c15", ia16, 32'h3);

    tick(3);
    chk("ld_dreq", dreq16, 32'h1);
    chk("ld_rw", rw16, 32'h1);
    chk("ld_da", da16, 32'h3);
    dack16 = 1'b1; dd_en = 1'b1; dd_val = 16'hBEEF;
    tick(1);
    dack16 = 1'b0; dd_en = 1'b0;
    chk("ld_dreq_off", dreq16, 32'h0);
    chk("ld_ia_c19", ia16, 32'h3);
    tick(1);
    chk("ld_ia_c20", ia16, 32'h4);
    chk("ld_r4", u16.rf[4], 32'hBEEF);

    tick(12);
    chk("br_taken", ia16, 32'h10);
    tick(8);
    chk("br_not_taken", ia16, 32'h12);
    tick(4);
    chk("br_prog_halt", halted16, 32'h1);

    // Reset in the middle of a stalled store, then a clean restart.
    restart16();
    tick(12);
    chk("mr_dreq_pre", dreq16, 32'h1);
    #2 rst16 = 1'b0;
    #1;
    chk("mr_dreq", dreq16, 32'h0);
    chk("mr_rw", rw16, 32'h1);
    chk("mr_ia", ia16, 32'h0);
    dd_en = 1'b1; dd_val = 16'h1234;
    #1;
    chk("mr_dd_released", dd16, 32'h1234);
    dd_en = 1'b0;
    @(negedge ck) rst16 = 1'b1;
    dack16 = 1'b1;   // stray acknowledge while idle
    tick(4);
    chk("mr_ia_1", ia16, 32'h1);
    chk("mr_r1", u16.rf[1], 32'h5);
    tick(4);
    dack16 = 1'b0;
    chk("mr_ia_2", ia16, 32'h2);

    // Wide core.
    rom32[0]  = 16'hC1FF;  // LI  R1,FF
    rom32[1]  = 16'hC21F;  // LI  R2,31
    rom32[2]  = 16'h3312;  // SHL R3,R1,R2
    rom32[3]  = 16'hC420;  // LI  R4,32
    rom32[4]  = 16'h3514;  // SHL R5,R1,R4
    rom32[5]  = 16'hC701;  // LI  R7,1
    rom32[6]  = 16'h1607;  // SUB R6,R0,R7
    rom32[7]  = 16'h2832;  // SHR R8,R3,R2
    rom32[8]  = 16'hC90B;  // LI  R9,0B
    rom32[9]  = 16'h8909;  // JMP R9,R9
    rom32[10] = 16'hCA77;  // LI  R10,77 (skipped)
    rom32[11] = 16'hF000;  // HALT
    @(negedge ck) rst32 = 1'b1;
    tick(50);
    chk("w32_shl31", u32.rf[3], 32'h8000_0000);
    chk("w32_shl32", u32.rf[5], 32'h0);
    chk("w32_sub_wrap", u32.rf[6], 32'hFFFF_FFFF);
    chk("w32_shr31", u32.rf[8], 32'h1);
    chk("w32_jmp_link", u32.rf[9], 32'hA);
    chk("w32_jmp_skip", u32.rf[10], 32'h0);
    chk("w32_ia", ia32, 32'hB);
    chk("w32_halted", halted32, 32'h1);
    chk("w32_idle_bus", {rw32, dreq32}, 32'h2);
    chk("w32_da", da32, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cpu_mc.md
Name: cpu_mc

Overview:
- Next-generation multicycle processor core.
- Data/address width is parametrised.
- Data memory uses a wait-state handshake (DREQ/DACK), so slow memories stall the core.
- Flag-setting compare ops, load-immediate and halt are real instructions.
- Instruction word stays 16 bits: op[15:12], d[11:8], a[7:4], b[3:0], imm8 = [7:0].
- Sits between the instruction ROM (IA/ID) and the shared data-memory bus (DA/DD/RW).

Parameters:
- W, 16: data, register, PC and address width (W >= 8).
- RESET_PC, 0: PC value loaded at reset.

Ports:
- CK  in  1  clock, rising edge.
- RST  in  1  reset; one clock, reset is asynchronous and active-low.
- IA  out  W  instruction address, equals PC.
- ID  in  16  instruction word, valid combinationally for IA.
- DA  out  W  data address, registered.
- DD  inout  W  data bus; driven by core only while RW=0, else Z.
- RW  out  1  1 = read/idle, 0 = write.
- DREQ  out  1  data access request, registered.
- DACK  in  1  memory completes the access in the cycle it is high while DREQ=1.
- HALTED  out  1  high once a HALT has retired.

Behaviour:
- Reset (RST=0, async) sets:
  - PC=RESET_PC, state=FETCH, FLAG=0, all 16 RF entries=0.
  - RW=1, DREQ=0, DA=0, HALTED=0, DD released.
  - Reset during a memory access aborts it immediately.
- States are FETCH, DECODE, EXEC, MEM, WB and HALT.
- FETCH (1 cycle): INSTR<=ID. Go to DECODE.
- DECODE (1 cycle): A<=RF[a], B<=RF[b]. Go to EXEC.
- EXEC (1 cycle): compute the result and next PC.
  - Load/store: DA<=address, DREQ<=1, RW<=0 for store, then go to MEM.
  - All other ops go to WB.
- MEM (>=1 cycle): hold DREQ/DA/RW until a cycle with DACK=1.
  - In that cycle, a load captures DD.
  - Next state is WB, with DREQ<=0 and RW<=1.
  - DACK while DREQ=0 is ignored.
- WB (1 cycle): write rd if the op writes, PC<=next PC, go to FETCH.
  - HALT goes to the HALT state instead, with HALTED<=1.
- HALT is terminal; only reset exits it.
- Latency: 4 cycles per instruction for non-memory ops; 4+N for load/store, where N = MEM cycles (N=1 if DACK is already high on the first MEM cycle).
- Opcodes (ALU results are W bits, wrap mod 2^W):
  - 0 ADD rd=A+B
  - 1 SUB rd=A-B
  - 2 SHR rd=A>>B, logical; B>=W gives 0
  - 3 SHL rd=A<<B; B>=W gives 0
  - 4 OR
  - 5 AND
  - 6 NOT rd=~A
  - 7 XOR
  - 8 JMP: rd=PC+1, PC=B
  - 9 BR: PC = FLAG ? B : PC+1; no write
  - A ST: mem[B]<=A; no write
  - B LD: rd=mem[A]
  - C LI: rd=zero-extended imm8
  - D CEQ: FLAG=(A==B); no write
  - E CLT: FLAG=(A<B), unsigned; no write
  - F HALT
- The PC increment wraps at 2^W-1 to 0.
- A read of register rd in the same instruction that writes it sees the old value.
- JMP with d==b still jumps to the old B.
- FLAG changes only in WB of CEQ/CLT; BR uses the FLAG value at its EXEC.

Decomposition:
- Package cpu_pkg holds:
  - opcode localparams OP_ADD..OP_HALT;
  - the state enum;
  - the field slice positions.
- Sub-module cpu_alu is purely combinational: (op, A, B) -> W-bit result.
- Register file, FSM and bus control stay in cpu_mc.

Test Plan:
- Reset then LI R1,0x05; LI R2,0x03; ADD R3,R1,R2; HALT -> R3=0x0008, HALTED=1 on cycle 16, IA stuck at 3.
- ST R1->[R2] with DACK delayed 3 cycles -> DREQ high exactly 3 cycles, RW=0 and DD=0x0005 throughout, DA=0x0003; next fetch at cycle 4+3.
- LD R4,[R2] with DACK on the first MEM cycle and memory returning 0xBEEF -> R4=0xBEEF, 5-cycle instruction.
- CEQ R1,R1 then BR to R5=0x0010 -> PC=0x0010. CLT R1,R2 (5<3 false) then BR -> PC+1.
- W=32: LI R1,0xFF; SHL R1,R1 by 31 -> 0x80000000; SHL by 32 -> 0. SUB 0-1 -> 0xFFFFFFFF.
- Assert RST low mid-MEM (DACK withheld) -> DREQ=0, RW=1, DD=Z immediately; PC=RESET_PC; execution restarts cleanly after release.
